// File: rtl/sd_init_sequencer_pkg.sv
// rtl/sd_init_sequencer_pkg.sv - shared encodings for the SD SPI-mode init sequencer
// Purpose: sequencer and handshake state encodings, error codes, command indices,
//          response read modes and fixed command arguments.
package sd_init_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWRUP,
      ST_CMD0,
      ST_CMD8,
      ST_CMD55,
      ST_ACMD41,
      ST_CMD58,
      ST_DONE,
      ST_ERROR
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_START,
      HS_RELEASE
   } hs_state_t;

   localparam logic [3:0] ERR_NONE   = 4'd0;
   localparam logic [3:0] ERR_CMD0   = 4'd1;
   localparam logic [3:0] ERR_CMD8   = 4'd2;
   localparam logic [3:0] ERR_ACMD41 = 4'd3;
   localparam logic [3:0] ERR_COMM   = 4'd4;
   localparam logic [3:0] ERR_CMD58  = 4'd5;

   localparam logic [5:0] IDX_CMD0   = 6'd0;
   localparam logic [5:0] IDX_CMD8   = 6'd8;
   localparam logic [5:0] IDX_CMD55  = 6'd55;
   localparam logic [5:0] IDX_ACMD41 = 6'd41;
   localparam logic [5:0] IDX_CMD58  = 6'd58;

   localparam logic [1:0] MODE_R1   = 2'b00;
   localparam logic [1:0] MODE_R3R7 = 2'b10;

   localparam logic [11:0] CMD8_CHECK     = 12'h1AA;
   localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
   localparam logic [31:0] ACMD41_HCS_ARG = 32'h4000_0000;

   // States in which a command is on the wire and commError is fatal.
   function automatic logic is_cmd_state(input state_t s);
      return s inside {ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58};
   endfunction

endpackage

// File: rtl/sd_cmd_handshake.sv
// rtl/sd_cmd_handshake.sv - single-command 4-phase start/finish handshake
// Purpose: raises o_start, waits for i_finish, latches the response, drops o_start,
//          waits for i_finish low and then pulses o_done for one cycle.
// Ports:   i_clk, i_nreset (sync, active low), i_enable (low holds idle),
//          i_finish, i_response[39:0] from the command master;
//          o_start to the command master, o_done pulse, o_response latched response.
module sd_cmd_handshake
   import sd_init_sequencer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_nreset,
   input  logic        i_enable,
   input  logic        i_finish,
   input  logic [39:0] i_response,
   output logic        o_start,
   output logic        o_done,
   output logic [39:0] o_response
);

   hs_state_t   r_state;
   hs_state_t   w_next_state;
   logic [39:0] r_response;

   // Dropping i_enable (sequencer left the command state) abandons any handshake.
   always_ff @(posedge i_clk) begin
      if (!i_nreset || !i_enable) begin
         r_state <= HS_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nreset) begin
         r_response <= '0;
      end else if (r_state == HS_START && i_finish) begin
         r_response <= i_response;
      end
   end

   always_comb begin
      w_next_state = r_state;
      o_start      = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         // One idle cycle guarantees command fields settle before o_start rises.
         HS_IDLE:    w_next_state = HS_START;
         HS_START: begin
            o_start = 1'b1;
            if (i_finish) begin
               w_next_state = HS_RELEASE;
            end
         end
         HS_RELEASE: begin
            if (!i_finish) begin
               o_done       = 1'b1;
               w_next_state = HS_IDLE;
            end
         end
         default:    w_next_state = HS_IDLE;
      endcase
   end

   assign o_response = r_response;

endmodule

// File: rtl/sd_init_sequencer.sv
// rtl/sd_init_sequencer.sv - SD card SPI-mode initialisation sequencer
// Purpose: power-up clocks, CMD0, CMD8, CMD55/ACMD41 loop and CMD58 through the
//          SPI command master; reports card version, capacity class and error code.
// Ports:   cpuClock, nReset (sync, active low), initStart (rising edge starts);
//          initBusy/initDone/initError, errorCode[3:0], cardV2, cardHC status;
//          commReset, spiClockEn, spiClockBS, cmdTransmitBit, cmdIndex[5:0],
//          cmdArgument[31:0], readMode[1:0], commStart to the command master;
//          commFinish, commError, readResponse[39:0] from the command master.
module sd_init_sequencer
   import sd_init_sequencer_pkg::*;
#(
   parameter int POWERUP_CYCLES = 20480,
   parameter int CMD0_RETRIES   = 8,
   parameter int ACMD41_RETRIES = 1000
) (
   input  logic        cpuClock,
   input  logic        nReset,
   input  logic        initStart,
   output logic        initBusy,
   output logic        initDone,
   output logic        initError,
   output logic [3:0]  errorCode,
   output logic        cardV2,
   output logic        cardHC,
   output logic        commReset,
   output logic        spiClockEn,
   output logic        spiClockBS,
   output logic        cmdTransmitBit,
   output logic [5:0]  cmdIndex,
   output logic [31:0] cmdArgument,
   output logic [1:0]  readMode,
   output logic        commStart,
   input  logic        commFinish,
   input  logic        commError,
   input  logic [39:0] readResponse
);

   localparam logic [15:0] PWR_LAST     = 16'(POWERUP_CYCLES - 1);
   localparam logic [9:0]  CMD0_LIMIT   = 10'(CMD0_RETRIES);
   localparam logic [9:0]  ACMD41_LIMIT = 10'(ACMD41_RETRIES);

   state_t      r_state, w_next_state;
   logic [3:0]  r_err_code, w_next_err;
   logic        r_card_v2, w_next_v2;
   logic        r_card_hc, w_next_hc;
   logic [9:0]  r_retry, w_next_retry, w_retry_inc;
   logic [15:0] r_pwr_cnt, w_next_pwr;
   logic        r_start_d;
   logic        w_start_edge;
   logic        w_cmd_active;
   logic        w_hs_done;
   logic [39:0] w_resp;
   logic        w_unused_resp;

   assign w_start_edge  = initStart & ~r_start_d;
   assign w_cmd_active  = is_cmd_state(r_state);
   assign w_retry_inc   = r_retry + 10'd1;
   assign w_unused_resp = ^{w_resp[31], w_resp[29:12]};

   assign errorCode      = r_err_code;
   assign cardV2         = r_card_v2;
   assign cardHC         = r_card_hc;
   assign spiClockBS     = 1'b0;
   assign cmdTransmitBit = 1'b1;

   sd_cmd_handshake u_handshake (
      .i_clk      (cpuClock),
      .i_nreset   (nReset),
      .i_enable   (w_cmd_active),
      .i_finish   (commFinish),
      .i_response (readResponse),
      .o_start    (commStart),
      .o_done     (w_hs_done),
      .o_response (w_resp)
   );

   always_ff @(posedge cpuClock) begin
      if (!nReset) begin
         r_state    <= ST_IDLE;
         r_err_code <= ERR_NONE;
         r_card_v2  <= 1'b0;
         r_card_hc  <= 1'b0;
         r_retry    <= '0;
         r_pwr_cnt  <= '0;
         r_start_d  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_err_code <= w_next_err;
         r_card_v2  <= w_next_v2;
         r_card_hc  <= w_next_hc;
         r_retry    <= w_next_retry;
         r_pwr_cnt  <= w_next_pwr;
         r_start_d  <= initStart;
      end
   end

   // Status and command-field outputs decode directly from the registered state,
   // so the command fields are stable for the whole command state.
   always_comb begin
      initBusy    = 1'b1;
      initDone    = 1'b0;
      initError   = 1'b0;
      commReset   = 1'b0;
      spiClockEn  = 1'b1;
      cmdIndex    = IDX_CMD0;
      cmdArgument = '0;
      readMode    = MODE_R1;
      case (r_state)
         ST_IDLE: begin
            initBusy   = 1'b0;
            commReset  = 1'b1;
            spiClockEn = 1'b0;
         end
         ST_DONE: begin
            initBusy = 1'b0;
            initDone = 1'b1;
         end
         ST_ERROR: begin
            initBusy   = 1'b0;
            initError  = 1'b1;
            commReset  = 1'b1;
            spiClockEn = 1'b0;
         end
         ST_CMD8: begin
            cmdIndex    = IDX_CMD8;
            cmdArgument = CMD8_ARG;
            readMode    = MODE_R3R7;
         end
         ST_CMD55:  cmdIndex = IDX_CMD55;
         ST_ACMD41: begin
            cmdIndex    = IDX_ACMD41;
            cmdArgument = r_card_v2 ? ACMD41_HCS_ARG : 32'h0;
         end
         ST_CMD58: begin
            cmdIndex = IDX_CMD58;
            readMode = MODE_R3R7;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      w_next_err   = r_err_code;
      w_next_v2    = r_card_v2;
      w_next_hc    = r_card_hc;
      w_next_retry = r_retry;
      w_next_pwr   = r_pwr_cnt;
      case (r_state)
         // Start edges are only honoured while no sequence is running.
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (w_start_edge) begin
               w_next_state = ST_PWRUP;
               w_next_err   = ERR_NONE;
               w_next_v2    = 1'b0;
               w_next_hc    = 1'b0;
               w_next_retry = '0;
               w_next_pwr   = '0;
            end
         end
         ST_PWRUP: begin
            if (r_pwr_cnt >= PWR_LAST) begin
               w_next_state = ST_CMD0;
               w_next_retry = '0;
            end else begin
               w_next_pwr = r_pwr_cnt + 16'd1;
            end
         end
         default: begin
            // commError wins even when commFinish arrives in the same cycle.
            if (commError) begin
               w_next_state = ST_ERROR;
               w_next_err   = ERR_COMM;
            end else if (w_hs_done) begin
               case (r_state)
                  ST_CMD0: begin
                     if (w_resp[7:0] == 8'h01) begin
                        w_next_state = ST_CMD8;
                     end else if (w_retry_inc >= CMD0_LIMIT) begin
                        w_next_state = ST_ERROR;
                        w_next_err   = ERR_CMD0;
                     end else begin
                        w_next_retry = w_retry_inc;
                     end
                  end
                  ST_CMD8: begin
                     w_next_retry = '0;
                     if (w_resp[39:32] == 8'h01 && w_resp[11:0] == CMD8_CHECK) begin
                        w_next_v2    = 1'b1;
                        w_next_state = ST_CMD55;
                     end else if (w_resp[34]) begin
                        // Illegal-command R1: a v1 card that does not know CMD8.
                        w_next_v2    = 1'b0;
                        w_next_state = ST_CMD55;
                     end else begin
                        w_next_state = ST_ERROR;
                        w_next_err   = ERR_CMD8;
                     end
                  end
                  ST_CMD55, ST_ACMD41: begin
                     if (r_state == ST_CMD55 && !w_resp[7]) begin
                        w_next_state = ST_ACMD41;
                     end else if (r_state == ST_ACMD41 && w_resp[7:0] == 8'h00) begin
                        w_next_state = r_card_v2 ? ST_CMD58 : ST_DONE;
                     end else if (w_retry_inc >= ACMD41_LIMIT) begin
                        // A malformed CMD55 reply also consumes one loop attempt.
                        w_next_state = ST_ERROR;
                        w_next_err   = ERR_ACMD41;
                     end else begin
                        w_next_retry = w_retry_inc;
                        w_next_state = ST_CMD55;
                     end
                  end
                  ST_CMD58: begin
                     if (w_resp[39:32] == 8'h00) begin
                        w_next_hc    = w_resp[30];
                        w_next_state = ST_DONE;
                     end else begin
                        w_next_state = ST_ERROR;
                        w_next_err   = ERR_CMD58;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

endmodule
